// File: rtl/msx_kb_pkg.sv
// Shared types and constants for the MSX keyboard matrix mapper.
package msx_kb_pkg;

  localparam int KB_ROWS = 11;
  localparam int KB_COLS = 8;

  // ps2_key field offsets
  localparam int PS2_TOG_BIT   = 10;
  localparam int PS2_PRESS_BIT = 9;
  localparam int PS2_EXT_BIT   = 8;
  localparam int PS2_CODE_MSB  = 7;
  localparam int PS2_CODE_LSB  = 0;

  typedef logic [KB_COLS-1:0] kb_row_t;
  typedef kb_row_t [KB_ROWS-1:0] kb_matrix_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } kb_lookup_t;

  // Builds a valid lookup entry for the scancode table.
  function automatic kb_lookup_t kb_entry(input logic [3:0] row, input logic [2:0] col);
    kb_lookup_t e;
    e.valid = 1'b1;
    e.row   = row;
    e.col   = col;
    return e;
  endfunction

endpackage

// File: rtl/msx_keymap_rom.sv
// Combinational set-2 scancode {ext, code} -> MSX international matrix position.
module msx_keymap_rom
  import msx_kb_pkg::*;
(
  input  logic [8:0]  key_i,
  output kb_lookup_t  res_o
);

  // Scancode table; anything not listed is an unmapped key.
  always_comb begin
    res_o = '0;
    case (key_i)
      // row 0: 0..7
      9'h045: res_o = kb_entry(4'd0, 3'd0);
      9'h016: res_o = kb_entry(4'd0, 3'd1);
      9'h01E: res_o = kb_entry(4'd0, 3'd2);
      9'h026: res_o = kb_entry(4'd0, 3'd3);
      9'h025: res_o = kb_entry(4'd0, 3'd4);
      9'h02E: res_o = kb_entry(4'd0, 3'd5);
      9'h036: res_o = kb_entry(4'd0, 3'd6);
      9'h03D: res_o = kb_entry(4'd0, 3'd7);
      // row 1: 8 9 - = \ [ ] ;
      9'h03E: res_o = kb_entry(4'd1, 3'd0);
      9'h046: res_o = kb_entry(4'd1, 3'd1);
      9'h04E: res_o = kb_entry(4'd1, 3'd2);
      9'h055: res_o = kb_entry(4'd1, 3'd3);
      9'h05D: res_o = kb_entry(4'd1, 3'd4);
      9'h054: res_o = kb_entry(4'd1, 3'd5);
      9'h05B: res_o = kb_entry(4'd1, 3'd6);
      9'h04C: res_o = kb_entry(4'd1, 3'd7);
      // row 2: ' ` , . / dead A B
      9'h052: res_o = kb_entry(4'd2, 3'd0);
      9'h00E: res_o = kb_entry(4'd2, 3'd1);
      9'h041: res_o = kb_entry(4'd2, 3'd2);
      9'h049: res_o = kb_entry(4'd2, 3'd3);
      9'h04A: res_o = kb_entry(4'd2, 3'd4);
      9'h061: res_o = kb_entry(4'd2, 3'd5);
      9'h01C: res_o = kb_entry(4'd2, 3'd6);
      9'h032: res_o = kb_entry(4'd2, 3'd7);
      // row 3: C D E F G H I J
      9'h021: res_o = kb_entry(4'd3, 3'd0);
      9'h023: res_o = kb_entry(4'd3, 3'd1);
      9'h024: res_o = kb_entry(4'd3, 3'd2);
      9'h02B: res_o = kb_entry(4'd3, 3'd3);
      9'h034: res_o = kb_entry(4'd3, 3'd4);
      9'h033: res_o = kb_entry(4'd3, 3'd5);
      9'h043: res_o = kb_entry(4'd3, 3'd6);
      9'h03B: res_o = kb_entry(4'd3, 3'd7);
      // row 4: K L M N O P Q R
      9'h042: res_o = kb_entry(4'd4, 3'd0);
      9'h04B: res_o = kb_entry(4'd4, 3'd1);
      9'h03A: res_o = kb_entry(4'd4, 3'd2);
      9'h031: res_o = kb_entry(4'd4, 3'd3);
      9'h044: res_o = kb_entry(4'd4, 3'd4);
      9'h04D: res_o = kb_entry(4'd4, 3'd5);
      9'h015: res_o = kb_entry(4'd4, 3'd6);
      9'h02D: res_o = kb_entry(4'd4, 3'd7);
      // row 5: S T U V W X Y Z
      9'h01B: res_o = kb_entry(4'd5, 3'd0);
      9'h02C: res_o = kb_entry(4'd5, 3'd1);
      9'h03C: res_o = kb_entry(4'd5, 3'd2);
      9'h02A: res_o = kb_entry(4'd5, 3'd3);
      9'h01D: res_o = kb_entry(4'd5, 3'd4);
      9'h022: res_o = kb_entry(4'd5, 3'd5);
      9'h035: res_o = kb_entry(4'd5, 3'd6);
      9'h01A: res_o = kb_entry(4'd5, 3'd7);
      // row 6: SHIFT CTRL GRAPH CAPS CODE F1 F2 F3
      9'h012: res_o = kb_entry(4'd6, 3'd0);
      9'h059: res_o = kb_entry(4'd6, 3'd0);
      9'h014: res_o = kb_entry(4'd6, 3'd1);
      9'h114: res_o = kb_entry(4'd6, 3'd1);
      9'h011: res_o = kb_entry(4'd6, 3'd2);
      9'h058: res_o = kb_entry(4'd6, 3'd3);
      9'h111: res_o = kb_entry(4'd6, 3'd4);
      9'h005: res_o = kb_entry(4'd6, 3'd5);
      9'h006: res_o = kb_entry(4'd6, 3'd6);
      9'h004: res_o = kb_entry(4'd6, 3'd7);
      // row 7: F4 F5 ESC TAB STOP BS SELECT RETURN
      9'h00C: res_o = kb_entry(4'd7, 3'd0);
      9'h003: res_o = kb_entry(4'd7, 3'd1);
      9'h076: res_o = kb_entry(4'd7, 3'd2);
      9'h00D: res_o = kb_entry(4'd7, 3'd3);
      9'h00A: res_o = kb_entry(4'd7, 3'd4);
      9'h066: res_o = kb_entry(4'd7, 3'd5);
      9'h083: res_o = kb_entry(4'd7, 3'd6);
      9'h05A: res_o = kb_entry(4'd7, 3'd7);
      9'h15A: res_o = kb_entry(4'd7, 3'd7);
      // row 8: SPACE HOME INS DEL LEFT UP DOWN RIGHT
      9'h029: res_o = kb_entry(4'd8, 3'd0);
      9'h16C: res_o = kb_entry(4'd8, 3'd1);
      9'h170: res_o = kb_entry(4'd8, 3'd2);
      9'h171: res_o = kb_entry(4'd8, 3'd3);
      9'h16B: res_o = kb_entry(4'd8, 3'd4);
      9'h175: res_o = kb_entry(4'd8, 3'd5);
      9'h172: res_o = kb_entry(4'd8, 3'd6);
      9'h174: res_o = kb_entry(4'd8, 3'd7);
      // row 9: keypad * + / 0 1 2 3 4
      9'h07C: res_o = kb_entry(4'd9, 3'd0);
      9'h079: res_o = kb_entry(4'd9, 3'd1);
      9'h14A: res_o = kb_entry(4'd9, 3'd2);
      9'h070: res_o = kb_entry(4'd9, 3'd3);
      9'h069: res_o = kb_entry(4'd9, 3'd4);
      9'h072: res_o = kb_entry(4'd9, 3'd5);
      9'h07A: res_o = kb_entry(4'd9, 3'd6);
      9'h06B: res_o = kb_entry(4'd9, 3'd7);
      // row 10: keypad 5 6 7 8 9 - (comma absent on PC) .
      9'h073: res_o = kb_entry(4'd10, 3'd0);
      9'h074: res_o = kb_entry(4'd10, 3'd1);
      9'h06C: res_o = kb_entry(4'd10, 3'd2);
      9'h075: res_o = kb_entry(4'd10, 3'd3);
      9'h07D: res_o = kb_entry(4'd10, 3'd4);
      9'h07B: res_o = kb_entry(4'd10, 3'd5);
      9'h071: res_o = kb_entry(4'd10, 3'd7);
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/msx_keymap.sv
// PS/2 event -> MSX 11x8 keyboard matrix, three-stage pipeline with registered row readout.
module msx_keymap
  import msx_kb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        kb_clear,
  input  logic [3:0]  kb_row,
  output logic [7:0]  kb_data,
  output logic        key_evt
);

  logic        tog_q;
  logic        evt_s;

  logic        s1_valid_q, s1_valid_d;
  logic        s1_press_q, s1_press_d;
  logic [8:0]  s1_key_q,   s1_key_d;

  kb_lookup_t  rom_s;
  kb_lookup_t  s2_q,       s2_d;
  logic        s2_press_q, s2_press_d;

  kb_matrix_t  matrix_q,   matrix_d;
  logic [7:0]  kb_data_q,  kb_data_d;
  logic        key_evt_q,  key_evt_d;

  msx_keymap_rom u_rom (
    .key_i (s1_key_q),
    .res_o (rom_s)
  );

  // Previous-toggle register: no reset so it keeps tracking ps2_key while reset_n is low,
  // which means the first edge after release never sees a spurious toggle.
  always_ff @(posedge clk) begin
    tog_q <= ps2_key[PS2_TOG_BIT];
  end

  // Next-state for all pipeline stages, the matrix and the readout.
  always_comb begin
    evt_s      = ps2_key[PS2_TOG_BIT] ^ tog_q;

    // stage 1: capture the raw event; a clear also discards a freshly sampled one
    s1_valid_d = evt_s & ~kb_clear;
    if (evt_s) begin
      s1_press_d = ps2_key[PS2_PRESS_BIT];
      s1_key_d   = {ps2_key[PS2_EXT_BIT], ps2_key[PS2_CODE_MSB:PS2_CODE_LSB]};
    end else begin
      s1_press_d = s1_press_q;
      s1_key_d   = s1_key_q;
    end

    // stage 2: register the table lookup; unmapped keys drop out here
    s2_d       = rom_s;
    s2_d.valid = rom_s.valid & s1_valid_q & ~kb_clear;
    s2_press_d = s1_press_q;

    // stage 3: matrix write (press clears, release sets); clear has priority
    matrix_d  = matrix_q;
    key_evt_d = 1'b0;
    if (kb_clear) begin
      matrix_d = '1;
    end else if (s2_q.valid && (s2_q.row < 4'(KB_ROWS))) begin
      matrix_d[s2_q.row][s2_q.col] = ~s2_press_q;
      key_evt_d                    = 1'b1;
    end else begin
      matrix_d  = matrix_q;
    end

    // readout: rows beyond the matrix read as all released
    if (kb_row < 4'(KB_ROWS)) begin
      kb_data_d = matrix_q[kb_row];
    end else begin
      kb_data_d = 8'hFF;
    end
  end

  // Pipeline, matrix and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_press_q <= 1'b0;
      s1_key_q   <= 9'h000;
      s2_q       <= '0;
      s2_press_q <= 1'b0;
      matrix_q   <= '1;
      kb_data_q  <= 8'hFF;
      key_evt_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_press_q <= s1_press_d;
      s1_key_q   <= s1_key_d;
      s2_q       <= s2_d;
      s2_press_q <= s2_press_d;
      matrix_q   <= matrix_d;
      kb_data_q  <= kb_data_d;
      key_evt_q  <= key_evt_d;
    end
  end

  assign kb_data = kb_data_q;
  assign key_evt = key_evt_q;

endmodule

// File: tb/tb_msx_keymap.sv
// Self-checking bench for msx_keymap: directed scenarios plus randomized events vs a matrix model.
module tb_msx_keymap;

  logic        clk;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        kb_clear;
  logic [3:0]  kb_row;
  logic [7:0]  kb_data;
  logic        key_evt;

  int passed;
  int total;
  int evt_cnt;

  // reference model: released = 1
  logic [7:0] mdl [0:10];

  // key table from the minimum mapping set: {ext, code, row, col}
  localparam int NMAP = 12;
  logic [0:0] t_ext  [0:NMAP-1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0] t_code [0:NMAP-1] = '{8'h45, 8'h16, 8'h1C, 8'h12, 8'h59, 8'h76, 8'h5A, 8'h29, 8'h6B, 8'h75, 8'h72, 8'h74};
  int         t_row  [0:NMAP-1] = '{0, 0, 2, 6, 6, 7, 7, 8, 8, 8, 8, 8};
  int         t_col  [0:NMAP-1] = '{0, 1, 6, 0, 0, 2, 7, 0, 4, 5, 6, 7};
  // keys with no MSX position
  localparam int NUNM = 4;
  logic [0:0] u_ext  [0:NUNM-1] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] u_code [0:NUNM-1] = '{8'h7E, 8'h1C, 8'h12, 8'h29};

  msx_keymap dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_key  (ps2_key),
    .kb_clear (kb_clear),
    .kb_row   (kb_row),
    .kb_data  (kb_data),
    .key_evt  (key_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_evt === 1'b1) evt_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic press, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], press, ext, code};
    tick();
  endtask

  task automatic read_row(input int r);
    kb_row = 4'(r);
    tick();
  endtask

  task automatic test_reset();
    ps2_key  = 11'h400;
    kb_clear = 1'b0;
    kb_row   = 4'd0;
    reset_n  = 1'b0;
    repeat (3) tick();
    total++;
    if (kb_data !== 8'hFF || key_evt !== 1'b0) begin
      $display("FAIL reset_hold: kb_data=%h key_evt=%b, expected FF/0", kb_data, key_evt);
    end else passed++;
    reset_n = 1'b1;
    for (int r = 0; r < 16; r++) begin
      read_row(r);
      total++;
      if (kb_data !== 8'hFF || key_evt !== 1'b0) begin
        $display("FAIL reset_release row %0d: kb_data=%h key_evt=%b, expected FF/0", r, kb_data, key_evt);
      end else passed++;
    end
  endtask

  task automatic test_press_release();
    logic [7:0] exp_seq [0:2];
    logic       evt_seq [0:2];
    kb_row = 4'd2;
    tick();
    for (int p = 1; p >= 0; p--) begin
      send(1'(p), 1'b0, 8'h1C);
      // cycles after the sampling edge: +1, +2, +3
      exp_seq = '{(p == 1) ? 8'hFF : 8'hBF, (p == 1) ? 8'hFF : 8'hBF, (p == 1) ? 8'hBF : 8'hFF};
      evt_seq = '{1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 3; k++) begin
        tick();
        total++;
        if (kb_data !== exp_seq[k] || key_evt !== evt_seq[k]) begin
          $display("FAIL press_release p=%0d edge+%0d: kb_data=%h key_evt=%b, expected %h/%b",
                   p, k + 1, kb_data, key_evt, exp_seq[k], evt_seq[k]);
        end else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    kb_row = 4'd8;
    tick();
    send(1'b1, 1'b1, 8'h75);
    send(1'b1, 1'b0, 8'h29);
    tick();
    total++;
    if (key_evt !== 1'b1) begin
      $display("FAIL b2b_evt_a: key_evt=%b, expected 1", key_evt);
    end else passed++;
    tick();
    total++;
    if (kb_data !== 8'hDF || key_evt !== 1'b1) begin
      $display("FAIL b2b_first: kb_data=%h key_evt=%b, expected DF/1", kb_data, key_evt);
    end else passed++;
    tick();
    total++;
    if (kb_data !== 8'hDE) begin
      $display("FAIL b2b_second: kb_data=%h, expected DE", kb_data);
    end else passed++;
    send(1'b0, 1'b1, 8'h75);
    send(1'b0, 1'b0, 8'h29);
    repeat (4) tick();
    total++;
    if (kb_data !== 8'hFF) begin
      $display("FAIL b2b_release: kb_data=%h, expected FF", kb_data);
    end else passed++;
  endtask

  task automatic test_unmapped();
    int c0;
    c0 = evt_cnt;
    send(1'b1, 1'b0, 8'h7E);
    repeat (4) tick();
    total++;
    if (evt_cnt != c0) begin
      $display("FAIL unmapped_evt: key_evt pulses=%0d, expected 0", evt_cnt - c0);
    end else passed++;
    for (int r = 0; r < 11; r++) begin
      read_row(r);
      total++;
      if (kb_data !== 8'hFF) begin
        $display("FAIL unmapped_row %0d: kb_data=%h, expected FF", r, kb_data);
      end else passed++;
    end
  endtask

  task automatic test_clear();
    send(1'b1, 1'b0, 8'h16);
    send(1'b1, 1'b0, 8'h45);
    repeat (4) tick();
    read_row(0);
    total++;
    if (kb_data !== 8'hFC) begin
      $display("FAIL clear_pre row0: kb_data=%h, expected FC", kb_data);
    end else passed++;
    send(1'b1, 1'b0, 8'h5A);
    tick();
    kb_clear = 1'b1;
    tick();
    kb_clear = 1'b0;
    repeat (3) tick();
    for (int r = 0; r < 11; r++) begin
      read_row(r);
      total++;
      if (kb_data !== 8'hFF) begin
        $display("FAIL clear_row %0d: kb_data=%h, expected FF", r, kb_data);
      end else passed++;
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp;
    send(1'b1, 1'b0, 8'h12);
    repeat (4) tick();
    for (int r = 0; r < 16; r++) begin
      exp = (r == 6) ? 8'hFE : 8'hFF;
      read_row(r);
      total++;
      if (kb_data !== exp) begin
        $display("FAIL sweep row %0d: kb_data=%h, expected %h", r, kb_data, exp);
      end else passed++;
    end
    send(1'b0, 1'b0, 8'h12);
    repeat (4) tick();
  endtask

  task automatic test_random();
    int c0;
    int exp_evts;
    int idx;
    logic press;
    logic [7:0] exp;
    kb_clear = 1'b1;
    tick();
    kb_clear = 1'b0;
    repeat (3) tick();
    for (int r = 0; r < 11; r++) mdl[r] = 8'hFF;
    for (int round = 0; round < 4; round++) begin
      c0       = evt_cnt;
      exp_evts = 0;
      for (int i = 0; i < 40; i++) begin
        kb_row = 4'($urandom_range(15));
        if ($urandom_range(3) != 0) begin
          idx   = int'($urandom_range(NMAP + NUNM - 1));
          press = 1'($urandom_range(1));
          if (idx < NMAP) begin
            mdl[t_row[idx]][t_col[idx]] = ~press;
            exp_evts++;
            send(press, t_ext[idx], t_code[idx]);
          end else begin
            send(press, u_ext[idx - NMAP], u_code[idx - NMAP]);
          end
        end else begin
          tick();
        end
      end
      repeat (4) tick();
      total++;
      if (evt_cnt - c0 != exp_evts) begin
        $display("FAIL random_evts round %0d: pulses=%0d, expected %0d", round, evt_cnt - c0, exp_evts);
      end else passed++;
      for (int r = 0; r < 16; r++) begin
        exp = (r < 11) ? mdl[r] : 8'hFF;
        read_row(r);
        total++;
        if (kb_data !== exp) begin
          $display("FAIL random_row round %0d row %0d: kb_data=%h, expected %h", round, r, kb_data, exp);
        end else passed++;
      end
    end
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    evt_cnt  = 0;
    reset_n  = 1'b0;
    ps2_key  = 11'h400;
    kb_clear = 1'b0;
    kb_row   = 4'd0;
    test_reset();
    test_press_release();
    test_back_to_back();
    test_unmapped();
    test_clear();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/msx_keymap.md
MSX_KEYMAP -- requirements
Module: msx_keymap

Interface
REQ-001 clk  input  1  system clock (core clock domain); all state SHALL be clocked on its rising edge.
REQ-002 reset_n  input  1  reset, asynchronous and active-low.
REQ-003 ps2_key  input  11  host keyboard event word: [10] toggles once per event, [9] 1=press/0=release, [8] E0-extended, [7:0] set-2 scancode.
REQ-004 kb_clear  input  1  synchronous pulse; releases all keys (OSD focus loss).
REQ-005 kb_row  input  4  row select from the keyboard-scan port (PPI port C[3:0]).
REQ-006 kb_data  output  8  column bits of the selected row, active-low (0 = pressed).
REQ-007 key_evt  output  1  one-cycle pulse when a mapped event changes the matrix.

Function
REQ-008 The block SHALL hold an 11-row x 8-column matrix, rows 0..10, with bit value 1 meaning released.
REQ-009 Event detection: an event SHALL be flagged in the cycle where ps2_key[10] differs from its registered previous value.
REQ-010 Pipeline: stage 1 SHALL latch {pressed, ext, code} on event; stage 2 SHALL register the lookup result {valid, row[3:0], col[2:0]}; stage 3 SHALL write the matrix bit.
REQ-011 Latency: the matrix bit, and a kb_data change for a matching kb_row, SHALL be visible 3 cycles after the clock edge that sampled the toggle.
REQ-012 Throughput: one event per cycle SHALL be accepted; back-to-back toggles SHALL each be applied in arrival order.
REQ-013 Write rule: press SHALL clear matrix[row][col]; release SHALL set it.
REQ-014 Unmapped {ext, code}: the event SHALL be dropped, with no matrix change and no key_evt.
REQ-015 key_evt SHALL pulse in the stage-3 cycle for valid lookups only, including writes that leave the bit value unchanged.
REQ-016 kb_data SHALL be registered: it SHALL equal matrix[kb_row] one cycle after kb_row or the matrix changes.
REQ-017 For kb_row 11..15, kb_data SHALL be 8'hFF.
REQ-018 kb_clear SHALL set all matrix bits to 1 on the next edge.
REQ-019 When kb_clear coincides with a stage-3 write, clear SHALL win, and the in-flight pipeline events SHALL be discarded.
REQ-020 Minimum mapping set (ext, code -> row, bit):
  - 0,45 -> 0,0 and 0,16 -> 0,1
  - 0,1C (A) -> 2,6
  - 0,12 and 0,59 (shifts) -> 6,0
  - 0,76 (Esc) -> 7,2 and 0,5A (Enter) -> 7,7
  - 0,29 (Space) -> 8,0
  - 1,6B -> 8,4; 1,75 -> 8,5; 1,72 -> 8,6; 1,74 -> 8,7
  - the full alphanumeric/function set per the MSX international matrix

Reset
REQ-021 While reset_n is low, the block SHALL hold: all matrix bits 1, kb_data = 8'hFF, key_evt = 0, pipeline valids 0.
REQ-022 The previous-toggle register SHALL be loaded from ps2_key[10] during reset, so that no event is generated on reset release.
REQ-023 Reset asserted mid-pipeline SHALL discard in-flight events.

Structure
REQ-024 Package msx_kb_pkg SHALL hold KB_ROWS = 11, the matrix typedef (array of 8-bit rows), the lookup-result struct {valid, row, col}, and the ps2_key field offsets.
REQ-025 The scancode table SHALL be the sub-module msx_keymap_rom: a combinational 9-bit {ext, code} -> lookup-result case table, registered by the parent as stage 2.

Verification
REQ-026 Reset release with ps2_key[10]=1 held -> no key_evt, and kb_data = FF for every row.
REQ-027 Toggle with {1,0,1C}, kb_row=2 -> kb_data = BF at edge+3 and key_evt pulses once; toggle with {0,0,1C} -> kb_data = FF.
REQ-028 Back-to-back toggles on consecutive cycles, press {1,1,75} then press {1,0,29}, kb_row=8 -> kb_data = DF, then DE one cycle later.
REQ-029 Toggle with {1,0,7E} (unmapped) -> no key_evt, and all rows unchanged.
REQ-030 Press 0,16 and 0,45 (row 0 = FC), then kb_clear in the same cycle as a stage-3 press of 0,5A -> all rows FF, including row 7.
REQ-031 kb_row swept 0..15 after pressing 0,12 -> row 6 = FE, rows 11..15 = FF, each value valid one cycle after kb_row changes.
